// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: FSM state encoding,
// the nop instruction returned on aborted fetches, default parameters and
// the instruction word selector used on fetch responses.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_I  = 3'd1,
    ST_WAIT_I = 3'd2,
    ST_REQ_D  = 3'd3,
    ST_WAIT_D = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int unsigned TIMEOUT_DEFAULT  = 255;

  // Last-grant encoding for the round-robin option.
  localparam logic GRANT_D = 1'b0;
  localparam logic GRANT_I = 1'b1;

  // A 64-bit beat carries two instruction words; address bit 2 picks one.
  function automatic logic [31:0] select_word(input logic [63:0] data,
                                              input logic        hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/mem_port_timeout.sv
// mem_port_timeout
// 8-bit response timeout counter for the memory port arbiter.
// Ports:
//   clk   core clock
//   rstn  asynchronous active-low reset
//   clr   restart counting from zero (request accepted by memory)
//   en    count this cycle (arbiter is waiting for a response)
//   hit   this is the TIMEOUT-th waiting cycle; abort the transaction
module mem_port_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic hit
);

  // hit fires in the cycle whose increment brings the count to TIMEOUT, so
  // the arbiter leaves the wait state after exactly TIMEOUT wait cycles.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] count_reg;
  logic [7:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign hit = en && !clr && (count_reg == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single core memory port between instruction fetch and the
// load/store unit, one outstanding transaction at a time. Fetch responses
// can be killed by jump/flush; every transaction is bounded by a timeout.
// Optional build macro: ARB_RR_EN selects round-robin between fetch and
// LSU when both request in IDLE; otherwise the LSU has fixed priority.
// Ports:
//   clk, rstn                          clock, async active-low reset
//   if_req/if_addr/if_kill             fetch request, address, kill
//   if_instr/if_rvalid                 fetched word, one-cycle valid pulse
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wmask   LSU request (held until done)
//   ls_rdata/ls_done                   load data, one-cycle done pulse
//   mem_valid/mem_ready/mem_we/mem_addr/mem_wdata/mem_wmask  request side
//   mem_rvalid/mem_rdata               response side
//   arb_err                            sticky timeout flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_instr,
  output logic        if_rvalid,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic [63:0] ls_rdata,
  output logic        ls_done,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        arb_err
);

  state_t state_reg;
  state_t state_next;

  logic grant_i;
  logic grant_d;
  logic resp_i;
  logic resp_d;
  logic drop_reg;
  logic to_clr;
  logic to_en;
  logic to_hit;

`ifdef ARB_RR_EN
  logic last_grant_reg;
`endif

  assign to_en  = (state_reg == ST_WAIT_I) || (state_reg == ST_WAIT_D);
  assign to_clr = ((state_reg == ST_REQ_I) || (state_reg == ST_REQ_D)) && mem_ready;

  mem_port_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rstn (rstn),
    .clr  (to_clr),
    .en   (to_en),
    .hit  (to_hit)
  );

  // mem_valid follows the request states directly, so it cannot drop
  // before mem_ready and clears immediately on reset.
  assign mem_valid = (state_reg == ST_REQ_I) || (state_reg == ST_REQ_D);

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    resp_i     = 1'b0;
    resp_d     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
`ifdef ARB_RR_EN
        if (ls_req && if_req) begin
          if (last_grant_reg == GRANT_D) begin
            grant_i = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
        end else if (ls_req) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_i = 1'b1;
        end
`else
        if (ls_req) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_i = 1'b1;
        end
`endif
        if (grant_d) begin
          state_next = ST_REQ_D;
        end else if (grant_i) begin
          state_next = ST_REQ_I;
        end
      end
      ST_REQ_I: begin
        if (mem_ready) state_next = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        if (mem_rvalid || to_hit) begin
          state_next = ST_IDLE;
          resp_i     = 1'b1;
        end
      end
      ST_REQ_D: begin
        if (mem_ready) state_next = ST_WAIT_D;
      end
      ST_WAIT_D: begin
        if (mem_rvalid || to_hit) begin
          state_next = ST_IDLE;
          resp_d     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_reg <= GRANT_D;
    end else if (grant_d) begin
      last_grant_reg <= GRANT_D;
    end else if (grant_i) begin
      last_grant_reg <= GRANT_I;
    end
  end
`endif

  // Request registers: captured at grant, held through the transaction.
  // A fetch is a plain read, so data and strobes are zeroed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_d) begin
      mem_we    <= ls_we;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
      mem_wmask <= ls_wmask;
    end else if (grant_i) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end
  end

  // Drop flag: a kill while the fetch is outstanding discards its response.
  // Leaving WAIT_I clears it so the next fetch starts clean.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_reg <= 1'b0;
    end else if (resp_i) begin
      drop_reg <= 1'b0;
    end else if (if_kill && ((state_reg == ST_REQ_I) || (state_reg == ST_WAIT_I))) begin
      drop_reg <= 1'b1;
    end
  end

  // Responses. A timeout completes the transaction with zero data (nop for
  // a fetch); a real mem_rvalid in the same cycle wins over the timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_instr  <= NOP_INSTR;
      if_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_done   <= 1'b0;
      arb_err   <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_done   <= 1'b0;
      if ((resp_i || resp_d) && !mem_rvalid) begin
        arb_err <= 1'b1;
      end
      // A kill arriving together with the response also drops it.
      if (resp_i && !drop_reg && !if_kill) begin
        if_rvalid <= 1'b1;
        if_instr  <= mem_rvalid ? select_word(mem_rdata, mem_addr[2]) : NOP_INSTR;
      end
      if (resp_d) begin
        ls_done  <= 1'b1;
        ls_rdata <= mem_rvalid ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single core memory port between instruction fetch and the load/store unit. It carries one outstanding transaction at a time and returns the fetched instruction word as a one-cycle valid pulse. It also drops fetch responses killed by jump or flush, and bounds every transaction with a response timeout. It sits between the fetch stage, the LSU and the memory/bus bridge.

Parameters:
TIMEOUT, 255, max cycles waiting in a wait state before abort (8-bit counter).
RESET_PC, 64'h80000000, value driven on mem_addr at reset (idle bus).

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level; addr sampled at grant
if_addr  in  64  fetch address, 4-byte aligned
if_kill  in  1  jump/flush; discard in-flight fetch
if_instr  out  32  fetched instruction
if_rvalid  out  1  one-cycle pulse, if_instr valid
ls_req  in  1  LSU request, held until ls_done
ls_we  in  1  1=store
ls_addr  in  64  data address
ls_wdata  in  64  store data
ls_wmask  in  8  byte strobes
ls_rdata  out  64  load data
ls_done  out  1  one-cycle pulse, LSU transaction complete
mem_valid  out  1  request to memory
mem_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  64  address
mem_wdata  out  64  write data
mem_wmask  out  8  strobes
mem_rvalid  in  1  response valid
mem_rdata  in  64  response data
arb_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rstn=0): state IDLE. mem_valid=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, mem_wmask=0. if_rvalid=0, if_instr=32'h13. ls_done=0, ls_rdata=0, arb_err=0. Drop flag=0, counter=0. Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
- IDLE: ls_req -> REQ_D (LSU fixed priority); else if_req -> REQ_I; else stay. Addr/data/mask/we are latched into mem_* registers on the transition.
- IDLE grant and if_kill in the same cycle: fetch still granted; the new if_addr is used.
- REQ_x: mem_valid=1. Address and data are held stable until mem_ready; mem_valid is never withdrawn. On mem_ready, go to WAIT_x and clear the counter.
- WAIT_x: on mem_rvalid, go to IDLE. A new grant is possible the next cycle, giving a minimum 3-cycle turnaround.
- Fetch response: if_instr = if_addr_latched[2] ? mem_rdata[63:32] : mem_rdata[31:0], registered. if_rvalid pulses the cycle after mem_rvalid, unless the drop flag is set.
- LSU response: ls_rdata registered from mem_rdata; ls_done pulses the cycle after mem_rvalid. Stores also wait for mem_rvalid as their ack.
- Drop flag: set by if_kill in REQ_I or WAIT_I. It is cleared on leaving WAIT_I. if_kill in the same cycle as mem_rvalid also drops.
- Timeout: counter increments each WAIT_x cycle. At count==TIMEOUT, return to IDLE, set arb_err (sticky until reset) and issue the response pulse. Data is 0; fetch returns 32'h13 (nop), subject to the drop flag.
- if_rvalid and ls_done are never asserted together. There is at most one transaction in flight.

Optional Feature:
ARB_RR_EN defined: a one-bit last-grant register (reset = data) gives round-robin between if_req and ls_req when both are pending in IDLE; a single requester is granted immediately.
Undefined: fixed LSU priority. Fetch may starve while ls_req is continuous.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams), NOP_INSTR=32'h13, RESET_PC default.
- Natural sub-module: mem_port_timeout. It holds the 8-bit counter with clear/enable inputs and a hit output.

Test Plan:
- Fetch: if_req=1, if_addr=0x80000004; mem_ready next cycle; mem_rvalid 2 cycles later with rdata=0x00500093_00000013 -> if_instr=0x00500093, if_rvalid pulses once.
- Contention: if_req and ls_req both high in IDLE, ls_addr=0x80001000 load -> mem_addr=0x80001000 first, ls_done, then fetch. With ARB_RR_EN, a second contention grants fetch first.
- Kill: fetch granted; if_kill pulses in WAIT_I -> response consumed, if_rvalid stays 0. The next if_req at 0x80000100 is served normally.
- Backpressure: mem_ready=0 for 5 cycles during a store with wmask=0x0F -> mem_valid, mem_addr, mem_wdata and mem_wmask stable all 5 cycles; ls_done after mem_rvalid.
- Timeout: TIMEOUT=4, no mem_rvalid -> return to IDLE after 4 wait cycles. arb_err=1, fetch returns 0x13 with if_rvalid pulse.
- Async reset: rstn low mid WAIT_D -> all outputs at reset values immediately without a clock edge. No ls_done after rstn release.
